sensor_level_conditioner: RTL

//  Upstream stage of the disaster detector. Takes a time-multiplexed 8-bit ADC sample stream
//  for four sensors (rain, seismic, wind, water level) and converts it to registered 2-bit

---
 rtl/disaster_pkg.sv | 35 +++
 rtl/level_channel.sv | 102 ++++++++++
 rtl/sensor_level_conditioner.sv | 69 ++++++
 3 files changed

// File: rtl/disaster_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disaster_pkg
//  Description : Shared channel indices, level encodings and the ADC
//                threshold classifier for the sensor level conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
package disaster_pkg;

    localparam int LVL_W = 2;

    localparam logic [1:0] CH_RAIN  = 2'd0;
    localparam logic [1:0] CH_SEIS  = 2'd1;
    localparam logic [1:0] CH_WIND  = 2'd2;
    localparam logic [1:0] CH_LEVEL = 2'd3;

    localparam logic [LVL_W-1:0] LVL_NORMAL   = 2'b00;
    localparam logic [LVL_W-1:0] LVL_ELEVATED = 2'b01;
    localparam logic [LVL_W-1:0] LVL_HIGH     = 2'b10;
    localparam logic [LVL_W-1:0] LVL_SEVERE   = 2'b11;

    function automatic logic [LVL_W-1:0] classify(
        input logic [7:0] d,
        input logic [7:0] t1,
        input logic [7:0] t2,
        input logic [7:0] t3
    );
        if (d >= t3)      return LVL_SEVERE;
        else if (d >= t2) return LVL_HIGH;
        else if (d >= t1) return LVL_ELEVATED;
        else              return LVL_NORMAL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/level_channel.sv
`default_nettype none
// ============================================================================
//  Module      : level_channel
//  Description : One sensor channel: classifier, downward hysteresis,
//                persistence filter and stale-sample watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module level_channel
    import disaster_pkg::*;
#(
    parameter int T1      = 64,
    parameter int T2      = 128,
    parameter int T3      = 192,
    parameter int HYST    = 8,
    parameter int PERSIST = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sample_en,
    input  logic [7:0]       i_sample_data,
    output logic [LVL_W-1:0] o_level,
    output logic             o_fault,
    output logic             o_changed
);

    localparam int PW = $clog2(PERSIST + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [7:0]    c_t1      = 8'(T1);
    localparam logic [7:0]    c_t2      = 8'(T2);
    localparam logic [7:0]    c_t3      = 8'(T3);
    localparam logic [PW-1:0] c_persist = PW'(PERSIST);
    localparam logic [TW-1:0] c_timeout = TW'(TIMEOUT);

    logic [LVL_W-1:0] r_level;
    logic [LVL_W-1:0] r_cand;
    logic [PW-1:0]    r_cnt;
    logic [TW-1:0]    r_idle;
    logic             r_fault;
    logic             r_changed;

    logic [LVL_W-1:0] w_raw;
    logic [8:0]       w_sum;
    logic [7:0]       w_hyst_data;
    logic [LVL_W-1:0] w_target;
    logic [PW-1:0]    w_next_cnt;
    logic             w_commit;
    logic [TW-1:0]    w_idle_inc;

    // Falling readings are judged as if HYST higher, so a level only drops
    // once the signal is clearly below its threshold.
    always_comb begin
        w_raw       = classify(i_sample_data, c_t1, c_t2, c_t3);
        w_sum       = {1'b0, i_sample_data} + 9'(HYST);
        w_hyst_data = w_sum[8] ? 8'hFF : w_sum[7:0];
        w_target    = (w_raw >= r_level) ? w_raw
                                         : classify(w_hyst_data, c_t1, c_t2, c_t3);
        w_next_cnt  = (w_target == r_cand) ? (r_cnt + PW'(1)) : PW'(1);
        w_commit    = (w_target != r_level) && (w_next_cnt == c_persist);
        w_idle_inc  = r_idle + TW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level   <= LVL_NORMAL;
            r_cand    <= LVL_NORMAL;
            r_cnt     <= '0;
            r_idle    <= '0;
            r_fault   <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            if (i_sample_en) begin
                r_idle  <= '0;
                r_fault <= 1'b0;
                if (w_target == r_level) begin
                    r_cand <= r_level;
                    r_cnt  <= '0;
                end else begin
                    r_cand <= w_target;
                    if (w_commit) begin
                        r_level   <= w_target;
                        r_cnt     <= '0;
                        r_changed <= 1'b1;
                    end else begin
                        r_cnt <= w_next_cnt;
                    end
                end
            end else if (r_idle != c_timeout) begin
                r_idle <= w_idle_inc;
                if (w_idle_inc == c_timeout) r_fault <= 1'b1;
            end
        end
    end

    assign o_level   = r_level;
    assign o_fault   = r_fault;
    assign o_changed = r_changed;

endmodule
`default_nettype wire

// File: rtl/sensor_level_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_level_conditioner
//  Description : Demultiplexes the shared ADC stream into four level
//                channels and maps their registered levels to output bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module sensor_level_conditioner
    import disaster_pkg::*;
#(
    parameter int T1      = 64,
    parameter int T2      = 128,
    parameter int T3      = 192,
    parameter int HYST    = 8,
    parameter int PERSIST = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [1:0] sample_ch,
    input  logic [7:0] sample_data,
    output logic       r1,
    output logic       r0,
    output logic       s1,
    output logic       s0,
    output logic       w1,
    output logic       w0,
    output logic       l1,
    output logic       l0,
    output logic [3:0] sensor_fault,
    output logic       level_update
);

    logic [LVL_W-1:0] w_level [4];
    logic [3:0]       w_en;
    logic [3:0]       w_changed;

    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
        assign w_en[gi] = sample_valid && (sample_ch == 2'(gi));

        level_channel #(
            .T1      (T1),
            .T2      (T2),
            .T3      (T3),
            .HYST    (HYST),
            .PERSIST (PERSIST),
            .TIMEOUT (TIMEOUT)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .i_sample_en   (w_en[gi]),
            .i_sample_data (sample_data),
            .o_level       (w_level[gi]),
            .o_fault       (sensor_fault[gi]),
            .o_changed     (w_changed[gi])
        );
    end

    assign {r1, r0} = w_level[CH_RAIN];
    assign {s1, s0} = w_level[CH_SEIS];
    assign {w1, w0} = w_level[CH_WIND];
    assign {l1, l0} = w_level[CH_LEVEL];

    // Change flags are per-channel flops, so this OR adds no input-to-output path.
    assign level_update = |w_changed;

endmodule
`default_nettype wire
